// File: rtl/tag_arbiter_rrip_pkg.sv
// Shared types and helpers for the I/D cache tag arbiters.
// Holds the sync walk state encoding and the one-hot and priority-encode helpers.
package tag_arbiter_rrip_pkg;

  localparam int RRPV_WID_D = 2;
  localparam int RRPV_MAX   = (1 << RRPV_WID_D) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_WAIT_WB = 2'd2,
    ST_DONE    = 2'd3
  } sync_state_t;

  function automatic logic [31:0] onehot_dec(input logic [4:0] idx);
    onehot_dec = 32'd1 << idx;
  endfunction

  // index of the highest set bit, 0 when the vector is empty
  function automatic logic [4:0] prio_enc_hi(input logic [31:0] vec);
    prio_enc_hi = 5'd0;
    for (int i = 0; i < 32; i++) begin
      prio_enc_hi = vec[i] ? 5'(i) : prio_enc_hi;
    end
  endfunction

endpackage

// File: rtl/tag_arbiter_rrip_victim_sel.sv
// RRIP victim choice for one set: lowest invalid way, else the largest RRPV (ties to the
// highest index), plus the aging delta RRPV_MAX - victim RRPV applied to the other ways on refill.
module tag_arbiter_rrip_victim_sel #(
  parameter int WAY_NUM    = 4,
  parameter int RRPV_WID   = 2,
  localparam int WAYSEL_WID = $clog2(WAY_NUM)
) (
  input  logic [WAY_NUM-1:0][RRPV_WID-1:0] rrpv,
  input  logic [WAY_NUM-1:0]               valid,
  output logic [WAYSEL_WID-1:0]            victim,
  output logic [RRPV_WID-1:0]              age_delta
);

  logic                  have_inv_s;
  logic [WAYSEL_WID-1:0] inv_way_s;
  logic [WAYSEL_WID-1:0] max_way_s;
  logic [RRPV_WID-1:0]   best_s;

  always_comb begin
    inv_way_s  = '0;
    max_way_s  = '0;
    best_s     = '0;
    have_inv_s = ~&valid;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      inv_way_s = !valid[w] ? WAYSEL_WID'(w) : inv_way_s;
    end
    for (int w = 0; w < WAY_NUM; w++) begin
      max_way_s = (rrpv[w] >= best_s) ? WAYSEL_WID'(w) : max_way_s;
      best_s    = (rrpv[w] >= best_s) ? rrpv[w] : best_s;
    end
    victim    = have_inv_s ? inv_way_s : max_way_s;
    age_delta = {RRPV_WID{1'b1}} - rrpv[victim];
  end

endmodule

// File: rtl/tag_arbiter_rrip.sv
// Set-associative tag store with RRIP replacement, dirty tracking and a dirty-line sync walk.
// Optional TAG_ARB_PERF_CNT_EN adds hit_cnt/miss_cnt access counters.
module tag_arbiter_rrip
  import tag_arbiter_rrip_pkg::*;
#(
  parameter int WAY_DEPTH    = 32,
  parameter int WAY_NUM      = 4,
  parameter int TAG_WID      = 14,
  parameter int RRPV_WID     = RRPV_WID_D,
  parameter int WBACK_ENABLE = 1,
  localparam int ENT_WID     = $clog2(WAY_DEPTH),
  localparam int WAYSEL_WID  = $clog2(WAY_NUM)
) (
`ifdef TAG_ARB_PERF_CNT_EN
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entry_read,
  input  logic                  entry_write,
  input  logic [TAG_WID-1:0]    address_tag,
  input  logic [ENT_WID-1:0]    address_ent,
  input  logic                  valid_clear,
  input  logic [TAG_WID-1:0]    refill_tag,
  input  logic                  line_refill,
  input  logic                  force_sync,
  input  logic                  writeback_ok,
  output logic                  line_miss,
  output logic                  replace_dirty,
  output logic [WAYSEL_WID-1:0] way_replace_sel,
  output logic [WAYSEL_WID-1:0] way_access_addr,
  output logic                  sync_busy,
  output logic                  sync_req,
  output logic [ENT_WID-1:0]    sync_ent,
  output logic                  sync_done
);

  localparam int                  RRPV_CEIL = (1 << RRPV_WID) - 1;
  localparam logic [RRPV_WID-1:0] RRPV_TOP  = RRPV_WID'(RRPV_CEIL);
  localparam logic [RRPV_WID-1:0] RRPV_INS  = RRPV_WID'(RRPV_CEIL - 1);

  logic [TAG_WID-1:0]               tag_r   [WAY_DEPTH][WAY_NUM];
  logic [WAY_NUM-1:0]               valid_r [WAY_DEPTH];
  logic [WAY_NUM-1:0]               dirty_r [WAY_DEPTH];
  logic [WAY_NUM-1:0][RRPV_WID-1:0] rrpv_r  [WAY_DEPTH];

  sync_state_t           state_r;
  logic [ENT_WID-1:0]    sync_ent_r, next_ent_s;
  logic [WAYSEL_WID-1:0] sync_way_r, next_way_s;
  logic                  sync_req_r, sync_done_r, sync_busy_r;
  logic                  sync_last_s, sync_line_dirty_s, victim_dirty_s;

  logic [WAY_NUM-1:0]               hit_s, sel_mask_s;
  logic [WAYSEL_WID-1:0]            hit_way_s, victim_s;
  logic [RRPV_WID-1:0]              age_delta_s;
  logic [WAY_NUM-1:0][RRPV_WID-1:0] aged_s;
  logic [RRPV_WID:0]                sum_s;
  logic                             access_s, any_hit_s, refill_en_s, hit_upd_s;

  tag_arbiter_rrip_victim_sel #(
    .WAY_NUM  (WAY_NUM),
    .RRPV_WID (RRPV_WID)
  ) u_victim_sel (
    .rrpv      (rrpv_r[address_ent]),
    .valid     (valid_r[address_ent]),
    .victim    (victim_s),
    .age_delta (age_delta_s)
  );

  always_comb begin
    hit_s = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      hit_s[w] = valid_r[address_ent][w] && (tag_r[address_ent][w] == address_tag);
    end
    hit_way_s   = WAYSEL_WID'(prio_enc_hi(32'(hit_s)));
    sel_mask_s  = WAY_NUM'(onehot_dec(5'(victim_s)));
    access_s    = entry_read | entry_write;
    any_hit_s   = |hit_s;
    refill_en_s = line_refill & ~valid_clear & ~writeback_ok & ~sync_busy_r;
    hit_upd_s   = access_s & any_hit_s & ~sync_busy_r & ~valid_clear & ~writeback_ok & ~line_refill;
    aged_s      = '0;
    sum_s       = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      sum_s     = {1'b0, rrpv_r[address_ent][w]} + {1'b0, age_delta_s};
      aged_s[w] = (sum_s > (RRPV_WID + 1)'(RRPV_CEIL)) ? RRPV_TOP : sum_s[RRPV_WID-1:0];
    end
    sync_last_s = (sync_ent_r == ENT_WID'(WAY_DEPTH - 1)) && (sync_way_r == WAYSEL_WID'(WAY_NUM - 1));
    next_way_s  = (sync_way_r == WAYSEL_WID'(WAY_NUM - 1)) ? '0 : sync_way_r + WAYSEL_WID'(1);
    next_ent_s  = (sync_way_r == WAYSEL_WID'(WAY_NUM - 1)) ? sync_ent_r + ENT_WID'(1) : sync_ent_r;
    sync_line_dirty_s = valid_r[sync_ent_r][sync_way_r] & dirty_r[sync_ent_r][sync_way_r];
    victim_dirty_s    = valid_r[address_ent][victim_s] & dirty_r[address_ent][victim_s];
    // the core is held off while the walk owns the victim/writeback path
    line_miss       = access_s & ~any_hit_s & ~sync_busy_r;
    way_access_addr = hit_way_s;
    way_replace_sel = sync_busy_r ? sync_way_r : victim_s;
    replace_dirty   = (WBACK_ENABLE != 0) ? (sync_busy_r ? sync_line_dirty_s : victim_dirty_s) : 1'b0;
    sync_busy       = sync_busy_r;
    sync_req        = sync_req_r;
    sync_ent        = sync_ent_r;
    sync_done       = sync_done_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sync_ent_r  <= '0;
      sync_way_r  <= '0;
      sync_req_r  <= 1'b0;
      sync_done_r <= 1'b0;
      sync_busy_r <= 1'b0;
    end else if (valid_clear) begin
      state_r     <= ST_IDLE;
      sync_req_r  <= 1'b0;
      sync_done_r <= 1'b0;
      sync_busy_r <= 1'b0;
    end else begin
      sync_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (force_sync) begin
            sync_ent_r  <= '0;
            sync_way_r  <= '0;
            sync_busy_r <= 1'b1;
            if (WBACK_ENABLE != 0) begin
              state_r <= ST_SCAN;
            end else begin
              state_r     <= ST_DONE;
              sync_done_r <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (sync_line_dirty_s) begin
            sync_req_r <= 1'b1;
            state_r    <= ST_WAIT_WB;
          end else if (sync_last_s) begin
            state_r     <= ST_DONE;
            sync_done_r <= 1'b1;
          end else begin
            sync_ent_r <= next_ent_s;
            sync_way_r <= next_way_s;
          end
        end
        ST_WAIT_WB: begin
          if (writeback_ok) begin
            sync_req_r <= 1'b0;
            if (sync_last_s) begin
              state_r     <= ST_DONE;
              sync_done_r <= 1'b1;
            end else begin
              sync_ent_r <= next_ent_s;
              sync_way_r <= next_way_s;
              state_r    <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          sync_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          sync_req_r  <= 1'b0;
          sync_busy_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < WAY_DEPTH; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        rrpv_r[s]  <= {WAY_NUM{RRPV_TOP}};
      end
    end else if (valid_clear) begin
      for (int s = 0; s < WAY_DEPTH; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
      end
    end else if (writeback_ok) begin
      if (state_r == ST_WAIT_WB) begin
        dirty_r[sync_ent_r][sync_way_r] <= 1'b0;
      end else if (!sync_busy_r) begin
        dirty_r[address_ent][victim_s] <= 1'b0;
      end
    end else if (refill_en_s) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (sel_mask_s[w]) begin
          valid_r[address_ent][w] <= 1'b1;
          dirty_r[address_ent][w] <= 1'b0;
          rrpv_r[address_ent][w]  <= RRPV_INS;
        end else begin
          rrpv_r[address_ent][w] <= aged_s[w];
        end
      end
    end else if (hit_upd_s) begin
      rrpv_r[address_ent][hit_way_s] <= '0;
      if (entry_write && (WBACK_ENABLE != 0)) begin
        dirty_r[address_ent][hit_way_s] <= 1'b1;
      end
    end
  end

  // tag RAM carries no reset; a line is only trusted once its valid bit is set
  always_ff @(posedge clk) begin
    if (refill_en_s) begin
      tag_r[address_ent][victim_s] <= refill_tag;
    end
  end

`ifdef TAG_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (access_s && any_hit_s && !sync_busy_r) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (line_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tag_arbiter_rrip.sv
// Randomized + directed bench for tag_arbiter_rrip against an array-based RRIP reference model.
module tb_tag_arbiter_rrip;

  localparam int DEPTH = 32;
  localparam int NUM   = 4;
  localparam int RMAX  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        entry_read, entry_write, valid_clear, line_refill, force_sync, writeback_ok;
  logic [13:0] address_tag, refill_tag;
  logic [4:0]  address_ent;
  logic        line_miss, replace_dirty, sync_busy, sync_req, sync_done;
  logic [1:0]  way_replace_sel, way_access_addr;
  logic [4:0]  sync_ent;
`ifdef TAG_ARB_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int m_valid [DEPTH][NUM];
  int m_dirty [DEPTH][NUM];
  int m_rrpv  [DEPTH][NUM];
  int m_tag   [DEPTH][NUM];
  int m_hits, m_miss;

  always #5 clk = ~clk;

  tag_arbiter_rrip dut (
`ifdef TAG_ARB_PERF_CNT_EN
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt),
`endif
    .clk             (clk),
    .rst             (rst),
    .entry_read      (entry_read),
    .entry_write     (entry_write),
    .address_tag     (address_tag),
    .address_ent     (address_ent),
    .valid_clear     (valid_clear),
    .refill_tag      (refill_tag),
    .line_refill     (line_refill),
    .force_sync      (force_sync),
    .writeback_ok    (writeback_ok),
    .line_miss       (line_miss),
    .replace_dirty   (replace_dirty),
    .way_replace_sel (way_replace_sel),
    .way_access_addr (way_access_addr),
    .sync_busy       (sync_busy),
    .sync_req        (sync_req),
    .sync_ent        (sync_ent),
    .sync_done       (sync_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < DEPTH; s++) begin
      for (int w = 0; w < NUM; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_rrpv[s][w]  = RMAX;
        m_tag[s][w]   = 0;
      end
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic m_clear();
    for (int s = 0; s < DEPTH; s++) begin
      for (int w = 0; w < NUM; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endtask

  function automatic int m_hit_way(input int s, input int t);
    int h = -1;
    for (int w = 0; w < NUM; w++) begin
      if (m_valid[s][w] != 0 && m_tag[s][w] == t) h = w;
    end
    return h;
  endfunction

  function automatic int m_victim(input int s);
    int best = 0;
    for (int w = 0; w < NUM; w++) begin
      if (m_valid[s][w] == 0) return w;
    end
    for (int w = 0; w < NUM; w++) begin
      if (m_rrpv[s][w] >= m_rrpv[s][best]) best = w;
    end
    return best;
  endfunction

  task automatic idle();
    entry_read   = 1'b0;
    entry_write  = 1'b0;
    valid_clear  = 1'b0;
    line_refill  = 1'b0;
    force_sync   = 1'b0;
    writeback_ok = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare combinational outputs with the model, then apply this cycle's update to the model
  task automatic cycle();
    int s, h, v, d;
    bit acc;
    #2;
    s   = int'(address_ent);
    h   = m_hit_way(s, int'(address_tag));
    v   = m_victim(s);
    acc = entry_read || entry_write;
    check_eq("line_miss", 32'(acc && h < 0), 32'(line_miss));
    if (h >= 0) check_eq("way_access_addr", 32'(way_access_addr), h);
    check_eq("way_replace_sel", 32'(way_replace_sel), v);
    check_eq("replace_dirty", 32'(replace_dirty), 32'(m_valid[s][v] != 0 && m_dirty[s][v] != 0));
    if (acc && h >= 0) m_hits++;
    if (acc && h < 0) m_miss++;
    if (valid_clear) begin
      m_clear();
    end else if (writeback_ok) begin
      m_dirty[s][v] = 0;
    end else if (line_refill) begin
      d = RMAX - m_rrpv[s][v];
      for (int w = 0; w < NUM; w++) begin
        if (w != v) m_rrpv[s][w] = (m_rrpv[s][w] + d > RMAX) ? RMAX : m_rrpv[s][w] + d;
      end
      m_tag[s][v]   = int'(refill_tag);
      m_valid[s][v] = 1;
      m_dirty[s][v] = 0;
      m_rrpv[s][v]  = RMAX - 1;
    end else if (acc && h >= 0) begin
      m_rrpv[s][h] = 0;
      if (entry_write) m_dirty[s][h] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int s, input int t);
    idle();
    address_ent = 5'(s);
    address_tag = 14'(t);
    refill_tag  = 14'(t);
    line_refill = 1'b1;
    cycle();
    idle();
  endtask

  task automatic access(input int s, input int t, input bit wr);
    idle();
    address_ent = 5'(s);
    address_tag = 14'(t);
    entry_read  = !wr;
    entry_write = wr;
    cycle();
    idle();
  endtask

  // full sync walk: requests must arrive in set-major, way-minor order of the model's dirty lines
  task automatic run_sync();
    int q_ent[$];
    int q_way[$];
    int cyc = 0;
    int nreq = 0;
    int d, e, w;
    for (int s = 0; s < DEPTH; s++) begin
      for (int k = 0; k < NUM; k++) begin
        if (m_valid[s][k] != 0 && m_dirty[s][k] != 0) begin
          q_ent.push_back(s);
          q_way.push_back(k);
        end
      end
    end
    d = q_ent.size();
    idle();
    force_sync = 1'b1;
    tick();
    force_sync = 1'b0;
    check_eq("sync_busy_start", 32'(sync_busy), 1);
    while (!sync_done && cyc < 1000) begin
      if (sync_req) begin
        nreq++;
        if (q_ent.size() > 0) begin
          e = q_ent.pop_front();
          w = q_way.pop_front();
          check_eq("sync_ent", 32'(sync_ent), e);
          check_eq("sync_way", 32'(way_replace_sel), w);
          check_eq("sync_replace_dirty", 32'(replace_dirty), 1);
          m_dirty[e][w] = 0;
        end
        writeback_ok = 1'b1;
        tick();
        writeback_ok = 1'b0;
      end else begin
        tick();
      end
      cyc++;
    end
    check_eq("sync_req_count", nreq, d);
    check_eq("sync_cycles", cyc, DEPTH * NUM + d);
    check_eq("sync_done", 32'(sync_done), 1);
    tick();
    check_eq("sync_done_pulse", 32'(sync_done), 0);
    check_eq("sync_busy_end", 32'(sync_busy), 0);
  endtask

  initial begin
    int op, n;
    idle();
    address_tag = 14'd0;
    address_ent = 5'd0;
    refill_tag  = 14'd0;
    m_reset();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_line_miss", 32'(line_miss), 0);
    check_eq("rst_replace_dirty", 32'(replace_dirty), 0);
    check_eq("rst_sync_busy", 32'(sync_busy), 0);
    check_eq("rst_sync_req", 32'(sync_req), 0);
    check_eq("rst_sync_done", 32'(sync_done), 0);
    check_eq("rst_sync_ent", 32'(sync_ent), 0);
`ifdef TAG_ARB_PERF_CNT_EN
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
`endif
    rst = 1'b0;

    // 1: cold miss then refill then hit
    address_ent = 5'd3;
    address_tag = 14'h55;
    entry_read  = 1'b1;
    #1;
    check_eq("t1_miss", 32'(line_miss), 1);
    check_eq("t1_victim", 32'(way_replace_sel), 0);
    cycle();
    refill(3, 'h55);
    address_ent = 5'd3;
    address_tag = 14'h55;
    entry_read  = 1'b1;
    #1;
    check_eq("t1_hit_miss", 32'(line_miss), 0);
    check_eq("t1_hit_way", 32'(way_access_addr), 0);
    cycle();
    idle();

    // 2: fill set 5, hit way 1, victim becomes way 3 and refill ages the rest
    for (int w = 0; w < NUM; w++) refill(5, 'h100 + w);
    access(5, 'h101, 1'b0);
    address_ent = 5'd5;
    #1;
    check_eq("t2_victim", 32'(way_replace_sel), 3);
    refill(5, 'h104);
    access(5, 'h101, 1'b0);
    access(5, 'h104, 1'b0);

    // 3: dirty way 0 of set 2 is eventually picked as victim
    for (int w = 0; w < NUM; w++) refill(2, 'h20 + w);
    access(2, 'h20, 1'b1);
    for (int w = 1; w < NUM; w++) access(2, 'h20 + w, 1'b0);
    for (int k = 0; k < 3; k++) refill(2, 'h30 + k);
    address_ent = 5'd2;
    #1;
    check_eq("t3_victim", 32'(way_replace_sel), 0);
    check_eq("t3_replace_dirty", 32'(replace_dirty), 1);
    writeback_ok = 1'b1;
    cycle();
    idle();
    #1;
    check_eq("t3_after_wb", 32'(replace_dirty), 0);

    // 4: sync walk over dirty (1,2) and (30,3)
    valid_clear = 1'b1;
    cycle();
    idle();
    for (int w = 0; w < 3; w++) refill(1, 'h40 + w);
    access(1, 'h42, 1'b1);
    for (int w = 0; w < NUM; w++) refill(30, 'h50 + w);
    access(30, 'h53, 1'b1);
    run_sync();
    run_sync();

    // 5: valid_clear aborts a sync waiting on writeback
    refill(7, 'h77);
    access(7, 'h77, 1'b1);
    force_sync = 1'b1;
    tick();
    force_sync = 1'b0;
    n = 0;
    while (!sync_req && n < 300) begin
      tick();
      n++;
    end
    check_eq("t5_req_seen", 32'(sync_req), 1);
    check_eq("t5_req_ent", 32'(sync_ent), 7);
    valid_clear = 1'b1;
    tick();
    valid_clear = 1'b0;
    m_clear();
    check_eq("t5_busy", 32'(sync_busy), 0);
    check_eq("t5_req", 32'(sync_req), 0);
    for (int k = 0; k < 6; k++) begin
      check_eq("t5_no_done", 32'(sync_done), 0);
      tick();
    end
    address_ent = 5'd7;
    address_tag = 14'h77;
    entry_read  = 1'b1;
    #1;
    check_eq("t5_miss", 32'(line_miss), 1);
    cycle();
    access(1, 'h42, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      idle();
      address_ent = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) address_ent = 5'($urandom_range(0, 31));
      address_tag = 14'($urandom_range(0, 7));
      op = int'($urandom_range(0, 99));
      if (op < 55) begin
        if ($urandom_range(0, 1) == 1) entry_write = 1'b1;
        else entry_read = 1'b1;
      end else if (op < 78) begin
        if (m_hit_way(int'(address_ent), int'(address_tag)) < 0) begin
          line_refill = 1'b1;
          refill_tag  = address_tag;
        end else begin
          entry_read = 1'b1;
        end
      end else if (op < 90) begin
        writeback_ok = 1'b1;
      end else if (op < 92) begin
        valid_clear = 1'b1;
      end
      cycle();
    end
    idle();
`ifdef TAG_ARB_PERF_CNT_EN
    check_eq("hit_cnt", hit_cnt, m_hits);
    check_eq("miss_cnt", miss_cnt, m_miss);
`endif
    run_sync();

    // 6: asynchronous reset in the middle of a scan
    force_sync = 1'b1;
    tick();
    force_sync = 1'b0;
    tick();
    tick();
    check_eq("t6_busy_before", 32'(sync_busy), 1);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check_eq("t6_busy", 32'(sync_busy), 0);
    check_eq("t6_req", 32'(sync_req), 0);
    check_eq("t6_done", 32'(sync_done), 0);
    check_eq("t6_sync_ent", 32'(sync_ent), 0);
    check_eq("t6_line_miss", 32'(line_miss), 0);
    check_eq("t6_replace_dirty", 32'(replace_dirty), 0);
`ifdef TAG_ARB_PERF_CNT_EN
    check_eq("t6_hit_cnt", hit_cnt, 0);
    check_eq("t6_miss_cnt", miss_cnt, 0);
`endif
    tick();
    rst = 1'b0;
    access(3, 'h55, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
